// File: rtl/id_hazard_forward_unit_pkg.sv
// Shared forwarding-select encodings and the in-flight destination slot record
// used by the ID hazard/forward unit.
package id_hazard_forward_unit_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_ALU = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       wr;
    logic       load;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/id_hazard_forward_unit_src_match.sv
// Compares one ID source register against the EXE (S1) and MEM (S2) shadow
// slots and picks the youngest producer.
module hfu_src_match
  import id_hazard_forward_unit_pkg::*;
(
  input  logic [4:0] src,
  input  logic       need,
  input  slot_t      s1,
  input  slot_t      s2,
  output fwd_sel_e   sel,
  output logic       load_hit,
  output logic       exe_hit
);

  logic s1_hit;
  logic s2_hit;

  always_comb begin
    s1_hit   = need & s1.valid & s1.wr & (s1.dst == src);
    s2_hit   = need & s2.valid & s2.wr & (s2.dst == src);
    load_hit = s1_hit & s1.load;
    exe_hit  = s1_hit & ~s1.load;
    sel      = FWD_REG;
    if (exe_hit)
      sel = FWD_ALU;
    else if (s2_hit)
      sel = FWD_MEM;
  end

endmodule

// File: rtl/id_hazard_forward_unit.sv
// ID-stage hazard detection and branch/JR operand forwarding, answering in the
// same cycle from a two-slot shadow of the EXE and MEM destinations.
module id_hazard_forward_unit
  import id_hazard_forward_unit_pkg::*;
#(
  parameter int unsigned BRANCH_EXE_STALL = 0,
  parameter int unsigned STALL_CNT_W      = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [31:0]            Instr1_IN,
  input  logic                   id_valid,
  input  logic                   id_freeze,
  input  logic                   reg_write,
  input  logic                   link_out,
  input  logic                   branch_out,
  input  logic                   jump_out,
  input  logic                   jump_reg_out,
  input  logic                   use_rd,
  input  logic                   mem_read,
  input  logic                   mem_write,
  output logic [1:0]             Branch_JR_select_A_FU,
  output logic [1:0]             Branch_JR_select_B_FU,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

  logic [5:0] opcode;
  logic [4:0] rs, rt, rd, dst;
  logic       wr, need_a, need_b, is_br, issue;
  logic       load_a, load_b, exe_a, exe_b;
  logic       unused_instr;
  fwd_sel_e   sel_a, sel_b;
  slot_t      s1, s2, entry;

  assign unused_instr = ^Instr1_IN[10:0];

  always_comb begin
    opcode = Instr1_IN[31:26];
    rs     = Instr1_IN[25:21];
    rt     = Instr1_IN[20:16];
    rd     = Instr1_IN[15:11];
    dst    = use_rd ? rd : (link_out ? 5'd31 : rt);
    wr     = reg_write & (dst != 5'd0);
    need_a = (rs != 5'd0) & ~(jump_out & ~jump_reg_out) & ~(link_out & ~branch_out);
    need_b = (rt != 5'd0) &
             (use_rd | mem_write | (branch_out & ((opcode == 6'd4) | (opcode == 6'd5))));
    is_br  = branch_out | jump_reg_out;
    entry  = '{valid: 1'b1, dst: dst, wr: wr, load: mem_read};
  end

  hfu_src_match u_match_a (
    .src      (rs),
    .need     (need_a),
    .s1       (s1),
    .s2       (s2),
    .sel      (sel_a),
    .load_hit (load_a),
    .exe_hit  (exe_a)
  );

  hfu_src_match u_match_b (
    .src      (rt),
    .need     (need_b),
    .s1       (s1),
    .s2       (s2),
    .sel      (sel_b),
    .load_hit (load_b),
    .exe_hit  (exe_b)
  );

  always_comb begin
    stall = load_a | load_b |
            ((BRANCH_EXE_STALL != 0) & is_br & (exe_a | exe_b));
    issue = id_valid & ~stall & ~id_freeze;
    Branch_JR_select_A_FU = stall ? FWD_REG : sel_a;
    Branch_JR_select_B_FU = stall ? FWD_REG : sel_b;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      s1          <= SLOT_BUBBLE;
      s2          <= SLOT_BUBBLE;
      stall_count <= '0;
    end else begin
      s2 <= s1;
      s1 <= issue ? entry : SLOT_BUBBLE;
      if (stall && (stall_count != '1))
        stall_count <= stall_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_hazard_forward_unit.sv
// Directed-vector bench: u0 uses defaults, u1 stalls branches on EXE producers
// and has a 2-bit counter so saturation shows up quickly.
module tb_id_hazard_forward_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr1_IN;
  logic        id_valid, id_freeze;
  logic        reg_write, link_out, branch_out, jump_out, jump_reg_out, use_rd;
  logic        mem_read, mem_write;

  logic [1:0]  sel_a0, sel_b0, sel_a1, sel_b1;
  logic        stall0, stall1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  id_hazard_forward_unit #(.BRANCH_EXE_STALL(0), .STALL_CNT_W(16)) u0 (
    .CLK(CLK), .RESET(RESET), .Instr1_IN(Instr1_IN), .id_valid(id_valid),
    .id_freeze(id_freeze), .reg_write(reg_write), .link_out(link_out),
    .branch_out(branch_out), .jump_out(jump_out), .jump_reg_out(jump_reg_out),
    .use_rd(use_rd), .mem_read(mem_read), .mem_write(mem_write),
    .Branch_JR_select_A_FU(sel_a0), .Branch_JR_select_B_FU(sel_b0),
    .stall(stall0), .stall_count(cnt0)
  );

  id_hazard_forward_unit #(.BRANCH_EXE_STALL(1), .STALL_CNT_W(2)) u1 (
    .CLK(CLK), .RESET(RESET), .Instr1_IN(Instr1_IN), .id_valid(id_valid),
    .id_freeze(id_freeze), .reg_write(reg_write), .link_out(link_out),
    .branch_out(branch_out), .jump_out(jump_out), .jump_reg_out(jump_reg_out),
    .use_rd(use_rd), .mem_read(mem_read), .mem_write(mem_write),
    .Branch_JR_select_A_FU(sel_a1), .Branch_JR_select_B_FU(sel_b1),
    .stall(stall1), .stall_count(cnt1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic id_clr;
    Instr1_IN = '0; id_valid = 1'b1; id_freeze = 1'b0;
    reg_write = 1'b0; link_out = 1'b0; branch_out = 1'b0; jump_out = 1'b0;
    jump_reg_out = 1'b0; use_rd = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic nop;
    id_clr();
  endtask

  task automatic rtype(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    id_clr();
    Instr1_IN = {6'd0, rs, rt, rd, 11'h020};
    reg_write = 1'b1; use_rd = 1'b1;
  endtask

  task automatic addi(input logic [4:0] rt, input logic [4:0] rs);
    id_clr();
    Instr1_IN = {6'd8, rs, rt, 16'h0001};
    reg_write = 1'b1;
  endtask

  task automatic lw(input logic [4:0] rt, input logic [4:0] rs);
    id_clr();
    Instr1_IN = {6'd35, rs, rt, 16'h0000};
    reg_write = 1'b1; mem_read = 1'b1;
  endtask

  task automatic sw(input logic [4:0] rt, input logic [4:0] rs);
    id_clr();
    Instr1_IN = {6'd43, rs, rt, 16'h0004};
    mem_write = 1'b1;
  endtask

  task automatic br(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    id_clr();
    Instr1_IN = {op, rs, rt, 16'h0010};
    branch_out = 1'b1;
  endtask

  task automatic jr(input logic [4:0] rs);
    id_clr();
    Instr1_IN = {6'd0, rs, 15'd0, 6'd8};
    jump_out = 1'b1; jump_reg_out = 1'b1;
  endtask

  task automatic do_reset;
    id_clr(); id_valid = 1'b0; RESET = 1'b0;
    tick();
    RESET = 1'b1;
  endtask

  initial begin
    RESET = 1'b1;
    id_clr();
    #2;
    do_reset();

    // reset state, then ALU forward
    rtype(5'd3, 5'd1, 5'd2); #1;
    check_eq("rst_sel_a", sel_a0, 0);
    check_eq("rst_sel_b", sel_b0, 0);
    check_eq("rst_stall", stall0, 0);
    check_eq("rst_cnt", cnt0, 0);
    tick();
    rtype(5'd4, 5'd3, 5'd5); #1;
    check_eq("alu_fwd_a", sel_a0, 1);
    check_eq("alu_fwd_b", sel_b0, 0);
    check_eq("alu_fwd_stall", stall0, 0);
    check_eq("alu_fwd_a_bes", sel_a1, 1);
    tick();

    // load-use on beq
    lw(5'd3, 5'd1); #1;
    check_eq("lw_no_dep", sel_a0, 0);
    tick();
    br(6'd4, 5'd3, 5'd0); #1;
    check_eq("lu_stall", stall0, 1);
    check_eq("lu_sel_a", sel_a0, 0);
    check_eq("lu_sel_b", sel_b0, 0);
    check_eq("lu_stall_bes", stall1, 1);
    tick(); #1;
    check_eq("lu_after_sel_a", sel_a0, 2);
    check_eq("lu_after_stall", stall0, 0);
    check_eq("lu_cnt", cnt0, 1);
    check_eq("lu_after_sel_a_bes", sel_a1, 2);
    tick();

    // jr distance 2 then 3
    addi(5'd7, 5'd0); tick();
    nop(); tick();
    jr(5'd7); #1;
    check_eq("jr_dist2", sel_a0, 2);
    tick();
    addi(5'd7, 5'd0); tick();
    nop(); tick();
    nop(); tick();
    jr(5'd7); #1;
    check_eq("jr_dist3", sel_a0, 0);
    check_eq("jr_dist3_stall", stall0, 0);
    tick();

    // store data forwarding, S1 over S2, rs == rt
    addi(5'd8, 5'd0); tick();
    sw(5'd8, 5'd9); #1;
    check_eq("sw_sel_b", sel_b0, 1);
    check_eq("sw_sel_a", sel_a0, 0);
    tick();
    addi(5'd8, 5'd0); tick();
    addi(5'd8, 5'd0); tick();
    sw(5'd8, 5'd9); #1;
    check_eq("s1_wins", sel_b0, 1);
    tick();
    rtype(5'd10, 5'd8, 5'd8); #1;
    check_eq("same_src_a", sel_a0, 2);
    check_eq("same_src_b", sel_b0, 2);
    tick();

    // freeze drops the entry; stall with freeze still counts
    rtype(5'd5, 5'd1, 5'd1); id_freeze = 1'b1; tick();
    rtype(5'd6, 5'd5, 5'd0); #1;
    check_eq("freeze_no_entry", sel_a0, 0);
    tick();
    lw(5'd3, 5'd1); tick();
    br(6'd4, 5'd3, 5'd0); id_freeze = 1'b1; #1;
    check_eq("frz_stall", stall0, 1);
    tick();
    id_freeze = 1'b0; #1;
    check_eq("frz_after_sel_a", sel_a0, 2);
    check_eq("frz_cnt", cnt0, 2);
    check_eq("frz_cnt_bes", cnt1, 2);
    tick();

    // reset taken during a load-use stall
    lw(5'd3, 5'd1); tick();
    br(6'd4, 5'd3, 5'd0); #1;
    check_eq("mid_rst_stall", stall0, 1);
    RESET = 1'b0;
    tick();
    RESET = 1'b1; #1;
    check_eq("mid_rst_stall_after", stall0, 0);
    check_eq("mid_rst_sel_a", sel_a0, 0);
    check_eq("mid_rst_cnt", cnt0, 0);
    check_eq("mid_rst_cnt_bes", cnt1, 0);
    tick();

    // branch on EXE producer: u1 stalls, u0 forwards
    rtype(5'd2, 5'd1, 5'd1); tick();
    br(6'd5, 5'd2, 5'd0); #1;
    check_eq("bes_stall", stall1, 1);
    check_eq("bes_sel_a", sel_a1, 0);
    check_eq("nobes_stall", stall0, 0);
    check_eq("nobes_sel_a", sel_a0, 1);
    tick(); #1;
    check_eq("bes_after_sel_a", sel_a1, 2);
    check_eq("bes_after_stall", stall1, 0);
    check_eq("bes_cnt", cnt1, 1);
    check_eq("nobes_cnt", cnt0, 0);
    tick();
    rtype(5'd0, 5'd1, 5'd1); tick();
    br(6'd5, 5'd0, 5'd0); #1;
    check_eq("zero_dst_stall", stall1, 0);
    check_eq("zero_dst_a", sel_a1, 0);
    check_eq("zero_dst_b", sel_b1, 0);
    tick();

    // counter saturation on the 2-bit instance
    do_reset();
    for (int unsigned i = 0; i < 4; i++) begin
      lw(5'd3, 5'd1); tick();
      br(6'd4, 5'd3, 5'd0); tick();
      tick();
    end
    nop(); #1;
    check_eq("sat_cnt16", cnt0, 4);
    check_eq("sat_cnt2", cnt1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_hazard_forward_unit.md
# id_hazard_forward_unit

Hazard-detection and operand-forwarding responder for the ID stage. It receives ID's decode summary (`reg_write`, `link_out`, `branch_out`, `jump_out`, `jump_reg_out`, `use_rd`, plus instruction and memory flags) and returns the `Branch_JR_select_A_FU` / `Branch_JR_select_B_FU` selects that ID consumes. It also returns a load-use stall. Internally it keeps a two-slot shadow of the destination registers in flight in EXE and MEM, so it can answer in the same cycle.

## Interface
Parameters:
- `BRANCH_EXE_STALL`, default 0 — when 1, a branch/JR whose source is produced by the EXE-slot ALU instruction stalls 1 cycle instead of forwarding `Fwd_ALU_Result` (cuts the ALU→compare path).
- `STALL_CNT_W`, default 16 — width of the stall statistics counter.

Ports:
- `CLK`  in  1  — clock.
- `RESET`  in  1  — synchronous, active-low reset; one clock, sampled on rising `CLK`.
- `Instr1_IN`  in  32  — instruction currently in ID.
- `id_valid`  in  1  — ID holds a real instruction this cycle.
- `id_freeze`  in  1  — ID `WANT_FREEZE`; ID issues a bubble this cycle.
- `reg_write`, `link_out`, `branch_out`, `jump_out`, `jump_reg_out`, `use_rd`  in  1 each — ID decode flags.
- `mem_read`, `mem_write`  in  1 each — ID load/store flags.
- `Branch_JR_select_A_FU`  out  2 — select for rs.
- `Branch_JR_select_B_FU`  out  2 — select for rt.
- `stall`  out  1 — hold ID/IF this cycle; ID's instruction is not issued.
- `stall_count`  out  `STALL_CNT_W` — saturating count of stall cycles.

## Operation
- Destination of the ID instruction:
  - `dst = use_rd ? Instr[15:11] : (link_out ? 31 : Instr[20:16])`.
  - `wr = reg_write & (dst != 0)`.
- Source-A need: `need_a = (rs != 0) & !(jump_out & !jump_reg_out) & !(link_out & !branch_out)`.
- Source-B need: `need_b = (rt != 0) & (use_rd | mem_write | (branch_out & opcode ∈ {4,5}))`.
- Shadow slots: S1 is the EXE instruction; S2 is the MEM instruction. Each slot holds `{valid, dst[4:0], wr, load}`.
- Select per source s ∈ {rs, rt}, evaluated only when the matching need is set, otherwise 0:
  - S1 valid, wr, dst == s, and !load → 1 (ALU).
  - Else S2 valid, wr, dst == s → 2 (MEM).
  - Else 0 (register file).
  - S1 takes priority over S2 (youngest wins).
  - Value 3 is never driven.
- Stall is asserted when any of these holds for a needed source:
  - S1 matches and is a load (load-use);
  - `BRANCH_EXE_STALL = 1`, the ID instruction is a branch/JR, and S1 matches.

  While stall is asserted, both selects are forced to 0.
- Shadow advance on every non-reset clock:
  - S2 ← S1.
  - S1 ← ID entry if `id_valid & !stall & !id_freeze`; otherwise S1 ← bubble (valid = 0).
- `stall_count` increments on each cycle with `stall = 1` and saturates at all-ones.

## Timing
- Reset: S1 and S2 invalid, `stall_count` = 0. Selects and `stall` are therefore 0 in the first cycle after reset.
- Selects and `stall` are combinational from the current-cycle ID inputs and the registered shadow state: 0-cycle latency, settled before ID's clock edge.
- Load-use costs exactly 1 stall cycle. On the next cycle the load sits in S2 and the select is 2.
- A dependence exactly 3 or more instructions back yields select 0. The register file write in WB is visible to ID on the following cycle.
- Simultaneous cases:
  - rs == rt, both needed: both selects are equal.
  - S1 and S2 both match: S1 wins.
  - `stall` together with `id_freeze`: S1 ← bubble and the counter still increments.
- Reset taken mid-stall: shadow is cleared and the stall drops next cycle.
- `dst = 0` entries never forward.

## Structure
- Shared package constants: `FWD_REG = 2'd0`, `FWD_ALU = 2'd1`, `FWD_MEM = 2'd2`, and the slot struct `{valid, dst, wr, load}`.
- One sub-module, `hfu_src_match`. It takes a source register and its need flag plus S1/S2, and returns `{select, load_hit, exe_hit}`. It is instantiated twice, once for rs and once for rt.

## Test plan
- `add $3,$1,$2` then `sub $4,$3,$5` → second cycle: `select_A = 1`, `stall = 0`.
- `lw $3,0($1)` then `beq $3,$0` → one cycle `stall = 1` with both selects 0; next cycle `select_A = 2`; `stall_count = 1`.
- `addi $7,…`, a nop, then `jr $7` → `select_A = 2`. With 2 nops in between → `select_A = 0`.
- `addi $8,…` then `sw $8,4($9)` → `select_B = 1`, `select_A = 0`. Repeat with $8 in both S1 and S2 → S1 wins (select 1).
- `BRANCH_EXE_STALL = 1`: `add $2,…` then `bne $2,$0` → 1 stall cycle, then `select_A = 2`. Writer to $0 → selects stay 0, no stall.
- Assert `RESET = 0` during a load-use stall → next cycle `stall = 0`, selects 0, `stall_count = 0`.
